// File: rtl/rle_pkg.sv
// Shared types and helpers for the 8-coefficient run-length expander.
// An entry is {run[RUN_W-1:0], value[COEF_W-1:0]}, packed with scan-order entry k at slot (size-1-k).
package rle_pkg;

    localparam int COEF_W = 8;
    localparam int RUN_W  = 6;
    localparam int ENT_W  = 14;
    localparam int N      = 8;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LEAD  = 3'd1,
        ST_RUN   = 3'd2,
        ST_VAL   = 3'd3,
        ST_TRAIL = 3'd4
    } state_e;

    function automatic logic [3:0] clamp_size(input logic [3:0] size);
        return (size > 4'd8) ? 4'd8 : size;
    endfunction

    function automatic logic [ENT_W-1:0] entry_at(input logic [N*ENT_W-1:0] arr,
                                                  input logic [3:0]         size,
                                                  input logic [3:0]         k);
        logic [2:0] pos;
        logic [6:0] base;
        pos  = 3'(size - k - 4'd1);
        base = 7'(pos) * 7'(ENT_W);
        return arr[base +: ENT_W];
    endfunction

    function automatic logic [RUN_W-1:0] entry_run(input logic [ENT_W-1:0] ent);
        return ent[ENT_W-1:COEF_W];
    endfunction

    function automatic logic [COEF_W-1:0] entry_val(input logic [ENT_W-1:0] ent);
        return ent[COEF_W-1:0];
    endfunction

endpackage

// File: rtl/rle_expander_8_seg_check.sv
// Combinational segment validation: checks that a flagged segment expands to exactly 8 coefficients.
module rle_seg_check
    import rle_pkg::*;
(
    input  logic               flag_i,
    input  logic [2:0]         left_i,
    input  logic [2:0]         right_i,
    input  logic [N*ENT_W-1:0] array_i,
    input  logic [3:0]         size_i,
    output logic               bad_o
);

    logic [3:0] eff_size_s;
    logic [9:0] total_s;

    // Sum of leading/trailing zeros, entry count and every in-range entry run
    always_comb begin
        eff_size_s = clamp_size(size_i);
        total_s    = 10'(left_i) + 10'(right_i) + 10'(size_i);
        for (int k = 0; k < N; k++) begin
            total_s = total_s + ((4'(k) < eff_size_s)
                                 ? 10'(entry_run(entry_at(array_i, eff_size_s, 4'(k))))
                                 : 10'd0);
        end
        bad_o = flag_i && ((total_s != 10'd8) || (size_i > 4'd8) || (size_i == 4'd0));
    end

endmodule

// File: rtl/rle_expander_8.sv
// Run-length expander: turns one compressed segment into exactly 8 serial coefficients.
// Malformed segments are truncated or zero-padded to 8 beats and flagged on err.
module rle_expander_8
    import rle_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic               in_flag,
    input  logic [2:0]         in_left,
    input  logic [2:0]         in_right,
    input  logic [N*ENT_W-1:0] in_array,
    input  logic [3:0]         in_size,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [COEF_W-1:0]  out_data,
    output logic               out_last,
    output logic               err
);

    state_e              state_q, state_d;
    logic [RUN_W-1:0]    rem_q, rem_d;
    logic [3:0]          idx_q, idx_d;
    logic [2:0]          cnt_q, cnt_d;
    logic [2:0]          right_q;
    logic [N*ENT_W-1:0]  array_q;
    logic [3:0]          size_q;
    logic                out_valid_q, out_valid_d;
    logic [COEF_W-1:0]   out_data_q, out_data_d;
    logic                out_last_q, out_last_d;
    logic                err_q;

    logic                accept_s, beat_done_s, last_beat_s, seg_bad_s;
    logic [N*ENT_W-1:0]  src_array_s;
    logic [3:0]          src_size_s;
    logic [2:0]          src_right_s;
    logic [3:0]          ent_idx_s;
    logic [ENT_W-1:0]    ent_s;
    state_e              ent_state_s;
    logic [RUN_W-1:0]    ent_rem_s;

    assign last_beat_s = out_valid_q && (cnt_q == 3'd7);
    assign in_ready    = (state_q == ST_IDLE) || (last_beat_s && out_ready);
    assign accept_s    = in_valid && in_ready;
    assign beat_done_s = out_valid_q && out_ready;

    // At acceptance the segment is taken straight from the inputs, otherwise from the captured copy
    assign src_array_s = accept_s ? in_array : array_q;
    assign src_size_s  = accept_s ? clamp_size(in_size) : size_q;
    assign src_right_s = accept_s ? in_right : right_q;

    rle_seg_check u_seg_check (
        .flag_i  (in_flag),
        .left_i  (in_left),
        .right_i (in_right),
        .array_i (in_array),
        .size_i  (in_size),
        .bad_o   (seg_bad_s)
    );

    // First non-empty phase of the next entry (or trailing zeros when entries are exhausted)
    always_comb begin
        ent_idx_s = (!accept_s && (state_q == ST_VAL)) ? (idx_q + 4'd1) : 4'd0;
        ent_s     = entry_at(src_array_s, src_size_s, ent_idx_s);
        if (ent_idx_s < src_size_s) begin
            ent_state_s = (entry_run(ent_s) != {RUN_W{1'b0}}) ? ST_RUN : ST_VAL;
            ent_rem_s   = entry_run(ent_s);
        end else begin
            ent_state_s = ST_TRAIL;
            ent_rem_s   = RUN_W'(src_right_s);
        end
    end

    // State, captured segment and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            rem_q       <= {RUN_W{1'b0}};
            idx_q       <= 4'd0;
            cnt_q       <= 3'd0;
            right_q     <= 3'd0;
            array_q     <= {(N*ENT_W){1'b0}};
            size_q      <= 4'd0;
            out_valid_q <= 1'b0;
            out_data_q  <= {COEF_W{1'b0}};
            out_last_q  <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            rem_q       <= rem_d;
            idx_q       <= idx_d;
            cnt_q       <= cnt_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_last_q  <= out_last_d;
            err_q       <= accept_s && seg_bad_s;
            if (accept_s) begin
                right_q <= in_right;
                array_q <= in_array;
                size_q  <= src_size_s;
            end
        end
    end

    // Next-state: zero-length phases are skipped here so every cycle carries a beat
    always_comb begin
        state_d = state_q;
        rem_d   = rem_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        if (accept_s) begin
            cnt_d = 3'd0;
            idx_d = 4'd0;
            if (!in_flag) begin
                state_d = ST_TRAIL;
                rem_d   = {RUN_W{1'b0}};
            end else if (in_left != 3'd0) begin
                state_d = ST_LEAD;
                rem_d   = RUN_W'(in_left);
            end else begin
                state_d = ent_state_s;
                rem_d   = ent_rem_s;
            end
        end else if (beat_done_s) begin
            if (cnt_q == 3'd7) begin
                state_d = ST_IDLE;
                rem_d   = {RUN_W{1'b0}};
                idx_d   = 4'd0;
                cnt_d   = 3'd0;
            end else begin
                cnt_d = cnt_q + 3'd1;
                case (state_q)
                    ST_LEAD: begin
                        if (rem_q > 6'd1) begin
                            rem_d = rem_q - 6'd1;
                        end else begin
                            state_d = ent_state_s;
                            rem_d   = ent_rem_s;
                        end
                    end
                    ST_RUN: begin
                        if (rem_q > 6'd1) begin
                            rem_d = rem_q - 6'd1;
                        end else begin
                            state_d = ST_VAL;
                        end
                    end
                    ST_VAL: begin
                        idx_d   = ent_idx_s;
                        state_d = ent_state_s;
                        rem_d   = ent_rem_s;
                    end
                    ST_TRAIL: begin
                        rem_d = (rem_q != {RUN_W{1'b0}}) ? (rem_q - 6'd1) : {RUN_W{1'b0}};
                    end
                    default: begin
                        state_d = ST_IDLE;
                    end
                endcase
            end
        end else begin
            state_d = state_q;
        end
    end

    // Output values for the beat presented in the next cycle
    always_comb begin
        out_valid_d = (state_d != ST_IDLE);
        out_last_d  = out_valid_d && (cnt_d == 3'd7);
        if (state_d == ST_VAL) begin
            out_data_d = entry_val(entry_at(src_array_s, src_size_s, idx_d));
        end else begin
            out_data_d = {COEF_W{1'b0}};
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_last  = out_last_q;
    assign err       = err_q;

endmodule

// File: tb/tb_rle_expander_8.sv
// Scoreboard bench for rle_expander_8: a behavioural expansion model queues 8 beats per accepted segment.
module tb_rle_expander_8;
    import rle_pkg::*;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic               in_valid, in_ready, in_flag;
    logic [2:0]         in_left, in_right;
    logic [N*ENT_W-1:0] in_array;
    logic [3:0]         in_size;
    logic               out_valid, out_ready, out_last, err;
    logic [COEF_W-1:0]  out_data;

    int          checks = 0;
    int          errors = 0;
    logic [8:0]  exp_q[$];
    logic [8:0]  exp_e;
    logic        err_exp = 1'b0;
    logic        model_bad;
    int          hs_cnt = 0;
    int          gap_cnt = 0;
    logic        prev_stall = 1'b0;
    logic [7:0]  prev_data;
    logic        prev_last;
    logic        bp_mode = 1'b0;
    logic [3:0]  bp_pat = 4'b1001;
    logic [1:0]  bp_ph = 2'd0;
    logic [N*ENT_W-1:0] wf_arr, ra;
    logic [13:0] ent;
    logic        rf;
    logic [2:0]  rl, rr;
    logic [3:0]  rs;
    int          h0, g0;

    rle_expander_8 dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_flag(in_flag),
        .in_left(in_left), .in_right(in_right), .in_array(in_array), .in_size(in_size),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_last(out_last), .err(err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_push(input logic f, input logic [2:0] l, input logic [2:0] r,
                              input logic [N*ENT_W-1:0] a, input logic [3:0] s, output logic bad);
        logic [7:0]  seq[$];
        logic [13:0] e;
        int n, total;
        n     = (s > 4'd8) ? 8 : int'(s);
        total = int'(l) + int'(r) + int'(s);
        if (f) begin
            repeat (l) seq.push_back(8'h00);
            for (int k = 0; k < n; k++) begin
                e = 14'(a >> (14 * (n - 1 - k)));
                total += int'(e[13:8]);
                repeat (e[13:8]) seq.push_back(8'h00);
                seq.push_back(e[7:0]);
            end
            repeat (r) seq.push_back(8'h00);
        end
        for (int i = 0; i < 8; i++) begin
            exp_q.push_back({(i == 7), (i < seq.size()) ? seq[i] : 8'h00});
        end
        bad = f && ((total != 8) || (s > 4'd8) || (s == 4'd0));
    endtask

    // Monitor: scoreboard pops, err timing, stall stability, bubble counting
    always @(negedge clk) begin
        if (!rst_n) begin
            exp_q.delete();
            err_exp    = 1'b0;
            prev_stall = 1'b0;
        end else begin
            check("err", 32'(err), 32'(err_exp));
            if (prev_stall) begin
                check("stall_valid", 32'(out_valid), 32'd1);
                check("stall_data", 32'(out_data), 32'(prev_data));
                check("stall_last", 32'(out_last), 32'(prev_last));
            end
            if (!out_valid && exp_q.size() != 0) gap_cnt++;
            if (out_valid && out_ready) begin
                check("beat_pending", 32'(exp_q.size() != 0), 32'd1);
                if (exp_q.size() != 0) begin
                    exp_e = exp_q.pop_front();
                    check("data", 32'(out_data), 32'(exp_e[7:0]));
                    check("last", 32'(out_last), 32'(exp_e[8]));
                end
                check("in_ready_on_beat", 32'(in_ready), 32'(out_last));
                hs_cnt++;
            end
            prev_stall = out_valid && !out_ready;
            prev_data  = out_data;
            prev_last  = out_last;
            err_exp    = 1'b0;
            if (in_valid && in_ready) begin
                model_push(in_flag, in_left, in_right, in_array, in_size, model_bad);
                err_exp = model_bad;
            end
        end
    end

    // Downstream ready: always 1, or the 1,0,0,1 pattern under backpressure
    initial begin
        out_ready = 1'b1;
        forever begin
            @(posedge clk); #1;
            if (bp_mode) begin
                out_ready = bp_pat[bp_ph];
                bp_ph     = bp_ph + 2'd1;
            end else begin
                out_ready = 1'b1;
                bp_ph     = 2'd0;
            end
        end
    end

    task automatic send_seg(input logic f, input logic [2:0] l, input logic [2:0] r,
                            input logic [N*ENT_W-1:0] a, input logic [3:0] s);
        logic ok;
        ok       = 1'b0;
        in_flag  = f;
        in_left  = l;
        in_right = r;
        in_array = a;
        in_size  = s;
        in_valid = 1'b1;
        for (int i = 0; i < 100 && !ok; i++) begin
            @(negedge clk);
            ok = in_ready;
        end
        check("accept", 32'(ok), 32'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (exp_q.size() == 0 && !out_valid) break;
        end
        check("drain", 32'(exp_q.size()), 32'd0);
        repeat (2) @(posedge clk);
        #1;
    endtask

    initial begin
        in_valid = 1'b0; in_flag = 1'b0; in_left = 3'd0; in_right = 3'd0;
        in_array = '0;   in_size = 4'd0;
        #7;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_data", 32'(out_data), 32'd0);
        check("rst_out_last", 32'(out_last), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        @(posedge clk); #1;

        wf_arr        = '0;
        wf_arr[41:0]  = {14'h0005, 14'h01FD, 14'h0007};
        send_seg(1'b1, 3'd2, 3'd2, wf_arr, 4'd3);
        drain();

        send_seg(1'b0, 3'd7, 3'd5, 112'({$urandom, $urandom, $urandom, $urandom}), 4'd5);
        drain();

        bp_mode = 1'b1;
        h0 = hs_cnt;
        send_seg(1'b1, 3'd2, 3'd2, wf_arr, 4'd3);
        drain();
        check("bp_handshakes", 32'(hs_cnt - h0), 32'd8);
        bp_mode = 1'b0;

        h0 = hs_cnt;
        g0 = gap_cnt;
        send_seg(1'b1, 3'd2, 3'd2, wf_arr, 4'd3);
        send_seg(1'b1, 3'd7, 3'd0, 112'h0042, 4'd1);
        drain();
        check("b2b_beats", 32'(hs_cnt - h0), 32'd16);
        check("b2b_gaps", 32'(gap_cnt - g0), 32'd0);

        h0 = hs_cnt;
        send_seg(1'b1, 3'd7, 3'd3, 112'h0011, 4'd1);
        drain();
        check("malformed_beats", 32'(hs_cnt - h0), 32'd8);

        h0 = hs_cnt;
        send_seg(1'b1, 3'd2, 3'd2, wf_arr, 4'd3);
        for (int i = 0; i < 50 && hs_cnt < h0 + 3; i++) @(negedge clk);
        check("reach_beat4", 32'(hs_cnt - h0 >= 3), 32'd1);
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        check("midrst_valid", 32'(out_valid), 32'd0);
        check("midrst_last", 32'(out_last), 32'd0);
        check("midrst_data", 32'(out_data), 32'd0);
        repeat (2) @(negedge clk);
        @(posedge clk);
        #3 rst_n = 1'b1;
        @(posedge clk); #1;
        check("postrst_in_ready", 32'(in_ready), 32'd1);
        check("postrst_valid", 32'(out_valid), 32'd0);
        send_seg(1'b1, 3'd2, 3'd2, wf_arr, 4'd3);
        drain();

        for (int t = 0; t < 8; t++) begin
            rf = ($urandom_range(0, 5) != 0);
            rl = 3'($urandom_range(0, 7));
            rr = 3'($urandom_range(0, 7));
            rs = 4'($urandom_range(0, 8));
            ra = '0;
            for (int k = 0; k < int'(rs); k++) begin
                ent = {6'($urandom_range(0, 2)), 8'($urandom)};
                ra  = ra | (112'(ent) << (14 * (int'(rs) - 1 - k)));
            end
            bp_mode = (t % 2 == 1);
            send_seg(rf, rl, rr, ra, rs);
            drain();
        end
        bp_mode = 1'b0;

        check("total_gaps", 32'(gap_cnt), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
